// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for RISC-V DIV/DIVU/REM/REMU with pipeline stall control.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ALL_ZEROS = {XLEN{1'b0}};
  localparam logic [5:0]      LAST_STEP = 6'(XLEN - 1);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic            div0_q, div0_d, busy_q, busy_d, done_q, done_d;

  logic            a_neg_s, b_neg_s, accept_s, div0_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s, quo_step_s, rem_step_s, res_fin_s;
  logic [XLEN:0]   rem_shift_s, diff_s;

  assign a_neg_s  = ~funct3[0] & A[XLEN-1];
  assign b_neg_s  = ~funct3[0] & B[XLEN-1];
  assign a_mag_s  = a_neg_s ? (ALL_ZEROS - A) : A;
  assign b_mag_s  = b_neg_s ? (ALL_ZEROS - B) : B;
  assign div0_s   = (B == ALL_ZEROS);
  // Flush kills an issuing op before it is accepted, so that cycle is not frozen.
  assign accept_s = (state_q == S_IDLE) & start & funct3[2] & ~flush;

`ifdef DIV_EARLY_OUT_EN
  logic            ovf_s;
  logic [XLEN-1:0] special_res_s;
  assign ovf_s = ~funct3[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == ALL_ONES);
  assign special_res_s = div0_s ? (funct3[1] ? A : ALL_ONES)
                                : (funct3[1] ? ALL_ZEROS : {1'b1, {(XLEN-1){1'b0}}});
`endif

  // One restoring step on the magnitudes, plus sign fix-up of the final step.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[XLEN-1]};
    diff_s      = rem_shift_s - {1'b0, b_q};
    if (diff_s[XLEN]) begin
      rem_step_s = rem_shift_s[XLEN-1:0];
      quo_step_s = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step_s = diff_s[XLEN-1:0];
      quo_step_s = {quo_q[XLEN-2:0], 1'b1};
    end
    // Magnitude division by zero would give a negated quotient for negative A.
    if (div0_q) begin
      res_fin_s = is_rem_q ? a_q : ALL_ONES;
    end else if (is_rem_q) begin
      res_fin_s = r_neg_q ? (ALL_ZEROS - rem_step_s) : rem_step_s;
    end else begin
      res_fin_s = q_neg_q ? (ALL_ZEROS - quo_step_s) : quo_step_s;
    end
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d      = A;
          b_d      = b_mag_s;
          quo_d    = a_mag_s;
          rem_d    = ALL_ZEROS;
          cnt_d    = 6'd0;
          is_rem_d = funct3[1];
          q_neg_d  = a_neg_s ^ b_neg_s;
          r_neg_d  = a_neg_s;
          div0_d   = div0_s;
          state_d  = S_BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (div0_s || ovf_s) begin
            state_d  = S_DONE;
            result_d = special_res_s;
          end else begin
            state_d  = S_BUSY;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_step_s;
          rem_d = rem_step_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            state_d  = S_DONE;
            result_d = res_fin_s;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      a_q      <= ALL_ZEROS;
      b_q      <= ALL_ZEROS;
      quo_q    <= ALL_ZEROS;
      rem_q    <= ALL_ZEROS;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= ALL_ZEROS;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign stall  = accept_s | (state_q == S_BUSY);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed corner cases plus random ops vs. an arithmetic model.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_res = 32'd0;

  div_seq_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .A(A), .B(B),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 33;
`else
    return special ? 33 : 33;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {32'd0, result}, {32'd0, e.res});
        check("latency", 64'(cyc - e.cyc), 64'(e.lat));
        last_res = e.res;
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f3; A = a; B = b;
    #1;
    check("stall_issue", {63'd0, stall}, 64'd1);
    if (push) begin
      e.res = ref_div(f3, a, b);
      e.cyc = cyc;
      e.lat = ref_lat(f3, a, b);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Issue one op, optionally re-pulse start mid-flight, and check the stall window.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit inject);
    int n = 0;
    int stall_cnt = 1;
    issue(f3, a, b, 1'b1);
    forever begin
      @(negedge clk);
      if (done) break;
      if (stall) stall_cnt++;
      n++;
      if (inject && n == 4) begin
        start = 1'b1; funct3 = 3'b100; A = 32'd77; B = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (n > 100) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    start = 1'b0;
    check("stall_at_done", {63'd0, stall}, 64'd0);
    check("stall_cycles", 64'(stall_cnt), 64'(ref_lat(f3, a, b)));
  endtask

  initial begin
    #1;
    check("reset_outputs", {29'd0, done, busy, stall, result}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b100, 32'hFFFF_FFEC, 32'd4, 1'b0);   // DIV -20/4
    run_op(3'b111, 32'd10, 32'd3, 1'b0);          // REMU
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);   // REM -7/2
    run_op(3'b101, 32'd123, 32'd0, 1'b0);         // DIVU by zero
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0, 1'b0);   // signed DIV by zero, negative A
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0, 1'b0);

    // Flushed op: no done, result untouched.
    issue(3'b100, 32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {63'd0, busy}, 64'd0);
    check("flush_idle_stall", {63'd0, stall}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush_result_kept", {32'd0, result}, {32'd0, last_res});
    run_op(3'b100, 32'd100, 32'd7, 1'b0);

    // Flush beats a simultaneous start.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; A = 32'd9; B = 32'd3; flush = 1'b1;
    #1;
    check("flush_start_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;

    // Non-divide funct3 is ignored.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; A = 32'd50; B = 32'd5;
    #1;
    check("nondiv_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("nondiv_busy", {63'd0, busy}, 64'd0);

    run_op(3'b101, 32'd1000, 32'd7, 1'b1);       // start during BUSY ignored

    // Reset mid-operation.
    issue(3'b100, 32'd500, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {29'd0, done, busy, stall, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    repeat (40) @(negedge clk);
    check("reset_no_done_result", {32'd0, result}, 64'd0);
    run_op(3'b110, 32'd17, 32'd5, 1'b0);

    // Random ops, including divide-by-zero and signed overflow.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = b;
      endcase
      run_op(f3, a, b, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  EX stage holds a valid divide/remainder op this cycle.
REQ-005 SHALL have port funct3  input  3  op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port A  input  XLEN  dividend (rs1).
REQ-007 SHALL have port B  input  XLEN  divisor (rs2).
REQ-008 SHALL have port flush  input  1  pipeline kill of the in-flight op.
REQ-009 SHALL have port stall  output  1  freeze IF/ID/EX while the op is unfinished.
REQ-010 SHALL have port busy  output  1  FSM not in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port result  output  XLEN  quotient or remainder.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE.
REQ-014 SHALL accept an op in IDLE only when start=1 and funct3[2]=1; it SHALL latch A, B and funct3 and go to BUSY.
REQ-015 SHALL ignore start with funct3[2]=0 (stay IDLE, stall=0).
REQ-016 SHALL drive stall = (IDLE & accepted start) | BUSY, combinationally, so the issuing cycle is already frozen.
REQ-017 SHALL perform one restoring radix-2 step per cycle in BUSY using a 6-bit iteration counter, XLEN steps total, then go to DONE.
REQ-018 SHALL, in DONE, assert done=1, stall=0 for exactly one cycle, then return to IDLE.
REQ-019 SHALL give latency: start accepted at cycle 0 -> done at cycle XLEN+1 (33 for XLEN=32).
REQ-020 SHALL, for DIV/REM, divide magnitudes; quotient negated when A[XLEN-1]^B[XLEN-1]; remainder takes the sign of A.
REQ-021 SHALL, for DIVU/REMU, treat operands as unsigned.
REQ-022 SHALL, on B=0, return quotient all-ones and remainder = A (signed and unsigned).
REQ-023 SHALL, on signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM), return quotient 0x80000000, remainder 0.
REQ-024 SHALL hold result stable from done until the next accepted start.
REQ-025 SHALL ignore start while BUSY or DONE; operands are not re-sampled.
REQ-026 SHALL, on flush=1 in any state, go to IDLE next edge, suppress done, leave result unchanged; flush overrides a simultaneous start (op not accepted, stall=0 that cycle).

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, counter 0, result 0, done 0, busy 0, stall 0, independent of clk.
REQ-028 SHALL, on reset mid-operation, discard the op with no done pulse; first start after rst_n rises is accepted normally.

Configuration
REQ-029 SHALL honour macro DIV_EARLY_OUT_EN: when defined, B=0 and signed-overflow ops go IDLE->DONE directly (done at cycle 1, stall for one cycle only).
REQ-030 SHALL, without DIV_EARLY_OUT_EN, run all XLEN iterations for every op (done at cycle 33) with identical result values.

Verification
REQ-031 SHALL cover: DIV A=-20 B=4 -> stall high cycles 0..32, done at cycle 33, result 0xFFFFFFFB (-5).
REQ-032 SHALL cover: REMU A=10 B=3 -> result 1; REM A=-7 B=2 -> result 0xFFFFFFFF (-1).
REQ-033 SHALL cover: DIVU A=123 B=0 -> result 0xFFFFFFFF; REM A=0x80000000 B=0xFFFFFFFF -> result 0; done at cycle 1 with DIV_EARLY_OUT_EN, cycle 33 without.
REQ-034 SHALL cover: flush at cycle 10 of DIV A=100 B=7 -> IDLE at cycle 11, no done, result keeps prior value; next DIV 100/7 -> 14.
REQ-035 SHALL cover: start with funct3=000 -> no stall, no busy; start pulsed again during BUSY -> ignored, first op's result returned.
REQ-036 SHALL cover: rst_n low at cycle 5 of an op -> all outputs 0 immediately, no done after release.
